// File: rtl/lcd_64_to_32_bits_dfa_core.sv
// lcd_64_to_32_bits_dfa_core
// Avalon-ST data format adapter core for the LCD path: takes 64-bit beats
// (8 symbols, first symbol in the MSBs) and emits them as one or two 32-bit
// beats (4 symbols). sop/eop/empty are carried across the split.
// One input beat is held at a time. Outputs come only from registers, so
// there is no combinational path from in_* to out_*.
// Optional build macro: LCD_64_TO_32_DFA_PKT_CHECK_EN adds packet framing
// tracking and drives protocol_error; without it protocol_error is tied 0.
module lcd_64_to_32_bits_dfa_core #(
    parameter int SYMBOL_W    = 8,
    parameter int IN_SYMBOLS  = 8,
    parameter int OUT_SYMBOLS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [IN_SYMBOLS*SYMBOL_W-1:0]  in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_startofpacket,
    input  logic                            in_endofpacket,
    input  logic [2:0]                      in_empty,
    output logic [OUT_SYMBOLS*SYMBOL_W-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_startofpacket,
    output logic                            out_endofpacket,
    output logic [1:0]                      out_empty,
    output logic                            protocol_error
);

    localparam int IN_W  = IN_SYMBOLS * SYMBOL_W;
    localparam int OUT_W = OUT_SYMBOLS * SYMBOL_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;  // nothing held
    localparam logic [1:0] ST_HIGH  = 2'd1;  // upper half pending
    localparam logic [1:0] ST_LOW   = 2'd2;  // lower half pending

    logic [1:0]      state_reg, state_next;
    logic [IN_W-1:0] hold_data_reg, hold_data_next;
    logic            hold_sop_reg, hold_sop_next;
    logic            hold_eop_reg, hold_eop_next;
    logic [2:0]      hold_empty_reg, hold_empty_next;

    logic             accept;
    logic             load;
    logic             upper_is_last;
    logic [OUT_W-1:0] upper_word;
    logic [OUT_W-1:0] lower_word;

    // An eop beat with four or more unused symbols fits entirely in the upper half.
    assign upper_is_last = hold_eop_reg && hold_empty_reg[2];

    // The sink can take a new beat once the held one is about to drain completely.
    assign in_ready = !reset &&
                      ((state_reg == ST_EMPTY) ||
                       ((state_reg == ST_LOW) && out_ready) ||
                       ((state_reg == ST_HIGH) && out_ready && upper_is_last));

    assign accept = in_valid && in_ready;

    // Symbol lanes: symbol gi of each output half maps to symbol gi (upper)
    // or symbol gi+OUT_SYMBOLS (lower) of the held input beat.
    generate
        for (genvar gi = 0; gi < OUT_SYMBOLS; gi++) begin : g_lane
            assign upper_word[(OUT_SYMBOLS-1-gi)*SYMBOL_W +: SYMBOL_W] =
                hold_data_reg[(IN_SYMBOLS-1-gi)*SYMBOL_W +: SYMBOL_W];
            assign lower_word[(OUT_SYMBOLS-1-gi)*SYMBOL_W +: SYMBOL_W] =
                hold_data_reg[(OUT_SYMBOLS-1-gi)*SYMBOL_W +: SYMBOL_W];
        end
    endgenerate

    // Output beat decode from the held beat and the current half.
    always_comb begin
        out_valid         = (state_reg != ST_EMPTY);
        out_data          = '0;
        out_startofpacket = 1'b0;
        out_endofpacket   = 1'b0;
        out_empty         = 2'd0;
        case (state_reg)
            ST_HIGH: begin
                out_data          = upper_word;
                out_startofpacket = hold_sop_reg;
                out_endofpacket   = upper_is_last;
                // hold_empty >= 4 here, so subtracting 4 just drops bit 2.
                out_empty         = upper_is_last ? hold_empty_reg[1:0] : 2'd0;
            end
            ST_LOW: begin
                out_data          = lower_word;
                out_startofpacket = 1'b0;
                out_endofpacket   = hold_eop_reg;
                out_empty         = hold_eop_reg ? hold_empty_reg[1:0] : 2'd0;
            end
            default: ;
        endcase
    end

    // Next-state and hold-register load decision.
    always_comb begin
        state_next      = state_reg;
        hold_data_next  = hold_data_reg;
        hold_sop_next   = hold_sop_reg;
        hold_eop_next   = hold_eop_reg;
        hold_empty_next = hold_empty_reg;
        load            = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (out_ready) begin
                    if (!upper_is_last) begin
                        state_next = ST_LOW;
                    end else if (accept) begin
                        load       = 1'b1;
                        state_next = ST_HIGH;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            ST_LOW: begin
                if (out_ready) begin
                    if (accept) begin
                        load       = 1'b1;
                        state_next = ST_HIGH;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (load) begin
            hold_data_next  = in_data;
            hold_sop_next   = in_startofpacket;
            hold_eop_next   = in_endofpacket;
            // empty is meaningless on non-eop beats; keep it clean.
            hold_empty_next = in_endofpacket ? in_empty : 3'd0;
        end
    end

    // State and hold registers; reset discards any partially drained beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_EMPTY;
            hold_data_reg  <= '0;
            hold_sop_reg   <= 1'b0;
            hold_eop_reg   <= 1'b0;
            hold_empty_reg <= 3'd0;
        end else begin
            state_reg      <= state_next;
            hold_data_reg  <= hold_data_next;
            hold_sop_reg   <= hold_sop_next;
            hold_eop_reg   <= hold_eop_next;
            hold_empty_reg <= hold_empty_next;
        end
    end

`ifdef LCD_64_TO_32_DFA_PKT_CHECK_EN
    logic in_packet_reg, in_packet_next;
    logic protocol_error_reg, protocol_error_next;

    // Framing tracker: a sop inside a packet or a non-sop outside one is flagged.
    always_comb begin
        in_packet_next      = in_packet_reg;
        protocol_error_next = 1'b0;
        if (accept) begin
            protocol_error_next = in_startofpacket ? in_packet_reg : !in_packet_reg;
            if (in_endofpacket) begin
                in_packet_next = 1'b0;
            end else if (in_startofpacket) begin
                in_packet_next = 1'b1;
            end
        end
    end

    // Framing state and the one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_packet_reg      <= 1'b0;
            protocol_error_reg <= 1'b0;
        end else begin
            in_packet_reg      <= in_packet_next;
            protocol_error_reg <= protocol_error_next;
        end
    end

    assign protocol_error = protocol_error_reg;
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_64_to_32_bits_dfa_core.sv
// Testbench for lcd_64_to_32_bits_dfa_core: directed beats, expected 32-bit
// beats queued at issue time, independent monitor pops and compares.
module tb_lcd_64_to_32_bits_dfa_core;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  m;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [2:0]  in_empty;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [1:0]  out_empty;
    logic        protocol_error;

    int total;
    int bad;
    int perr_cnt;
    beat_t exp_q[$];

    beat_t prev_beat;
    logic  prev_stall;
    logic  prev_rst;

`ifdef LCD_64_TO_32_DFA_PKT_CHECK_EN
    localparam int PERR_EXP = 1;
`else
    localparam int PERR_EXP = 0;
`endif

    lcd_64_to_32_bits_dfa_core dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .protocol_error    (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
        beat_t b;
        b.d = d; b.s = s; b.e = e; b.m = m;
        exp_q.push_back(b);
    endtask

    // Drive one input beat and hold it until accepted; returns cycles spent waiting.
    task automatic send(input logic [63:0] d, input logic s, input logic e,
                        input logic [2:0] m, output int waits);
        bit got;
        in_data          = d;
        in_startofpacket = s;
        in_endofpacket   = e;
        in_empty         = m;
        in_valid         = 1'b1;
        waits            = 0;
        got              = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) got = 1'b1;
            else waits++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_timeout: beat %0h never accepted", d);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            $display("in  beat data=%016h sop=%0b eop=%0b empty=%0d waits=%0d", d, s, e, m, waits);
        end
    endtask

    // Monitor: compare every transferred output beat and check stall stability.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur.d = out_data; cur.s = out_startofpacket; cur.e = out_endofpacket; cur.m = out_empty;
        if (prev_stall && !prev_rst && !reset) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_beat", {26'd0, cur}, {26'd0, prev_beat});
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %0h expected none", cur);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", {26'd0, cur}, {26'd0, e});
                $display("out beat data=%08h sop=%0b eop=%0b empty=%0d", cur.d, cur.s, cur.e, cur.m);
            end
        end
        if (protocol_error === 1'b1) perr_cnt++;
        prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
        prev_beat  = cur;
        prev_rst   = reset;
    end

    initial begin
        int w;
        int w2;
        int pat[4];
        total = 0; bad = 0; perr_cnt = 0;
        prev_stall = 1'b0; prev_rst = 1'b1; prev_beat = '0;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

        // 1: reset with in_valid high
        reset = 1'b1; in_valid = 1'b1; in_data = 64'hDEADBEEF_DEADBEEF;
        in_startofpacket = 1'b1; in_endofpacket = 1'b1; in_empty = 3'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_perr", {63'd0, protocol_error}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;

        // 2: two-beat packet, sink always ready
        expect_beat(32'h00112233, 1'b1, 1'b0, 2'd0);
        expect_beat(32'h44556677, 1'b0, 1'b0, 2'd0);
        expect_beat(32'h8899AABB, 1'b0, 1'b0, 2'd0);
        expect_beat(32'hCCDDEEFF, 1'b0, 1'b1, 2'd0);
        send(64'h0011223344556677, 1'b1, 1'b0, 3'd7, w);
        send(64'h8899AABBCCDDEEFF, 1'b0, 1'b1, 3'd0, w2);
        chk("t2_waits_beat1", 64'(w), 64'd0);
        chk("t2_waits_beat2", 64'(w2), 64'd1);

        // 3: single-beat packets; eop with empty>=4 lets the next beat in at once
        expect_beat(32'h01020304, 1'b1, 1'b1, 2'd1);
        expect_beat(32'h11121314, 1'b1, 1'b1, 2'd0);
        expect_beat(32'hA0A1A2A3, 1'b1, 1'b0, 2'd0);
        expect_beat(32'hA4A5A6A7, 1'b0, 1'b1, 2'd3);
        send(64'h0102030405060708, 1'b1, 1'b1, 3'd5, w);
        send(64'h1112131415161718, 1'b1, 1'b1, 3'd4, w2);
        chk("t3_waits_next", 64'(w2), 64'd0);
        send(64'hA0A1A2A3A4A5A6A7, 1'b1, 1'b1, 3'd3, w2);
        chk("t3_waits_empty4", 64'(w2), 64'd0);

        // 4: same packet as 2 with sink backpressure 1,0,0,1,...
        expect_beat(32'h00112233, 1'b1, 1'b0, 2'd0);
        expect_beat(32'h44556677, 1'b0, 1'b0, 2'd0);
        expect_beat(32'h8899AABB, 1'b0, 1'b0, 2'd0);
        expect_beat(32'hCCDDEEFF, 1'b0, 1'b1, 2'd0);
        fork
            begin
                send(64'h0011223344556677, 1'b1, 1'b0, 3'd0, w);
                send(64'h8899AABBCCDDEEFF, 1'b0, 1'b1, 3'd0, w2);
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    out_ready = pat[i % 4][0];
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join

        // 5: reset while the lower half is pending
        expect_beat(32'h11111111, 1'b1, 1'b0, 2'd0);
        send(64'h1111111122222222, 1'b1, 1'b0, 3'd0, w);
        @(posedge clk); #1;
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_out_valid_after_rst", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        expect_beat(32'hAAAAAAAA, 1'b1, 1'b0, 2'd0);
        expect_beat(32'hBBBBBBBB, 1'b0, 1'b1, 2'd0);
        send(64'hAAAAAAAABBBBBBBB, 1'b1, 1'b1, 3'd0, w);

        // 6: two sop beats without an intervening eop
        expect_beat(32'h01010101, 1'b1, 1'b0, 2'd0);
        expect_beat(32'h02020202, 1'b0, 1'b0, 2'd0);
        expect_beat(32'h03030303, 1'b1, 1'b0, 2'd0);
        expect_beat(32'h04040404, 1'b0, 1'b1, 2'd0);
        send(64'h0101010102020202, 1'b1, 1'b0, 3'd0, w);
        chk("t6_perr_first", {63'd0, protocol_error}, 64'd0);
        send(64'h0303030304040404, 1'b1, 1'b1, 3'd0, w);
        chk("t6_perr_pulse", {63'd0, protocol_error}, 64'(PERR_EXP));
        @(posedge clk); #1;
        chk("t6_perr_clear", {63'd0, protocol_error}, 64'd0);

        // drain
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("perr_count", 64'(perr_cnt), 64'(PERR_EXP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
